mesh_seq_ctrl: RTL and testbench
================================

Name: mesh_seq_ctrl

Overview:
- Job sequencer for the 2-D PE mesh; it owns the mesh's global_state, x-vector, config-broadcast and result interfaces.
- Streams ROWS*COLS weights over the cfg bus, then for each of N input vectors drives an x-load phase and an accumulate phase.
- Captures each row result and hands it downstream on a valid/ready port.
- Sits between the host/DMA streams and the mesh instance.

Parameters:
- DW, 8, element width.
- ROWS, 4, mesh rows.
- COLS, 4, mesh columns.
- ROW_W, 2, row-index width.
- COL_W, 2, column-index width.
- XLOAD_CYCLES, ROWS, cycles spent in global_state 1 per vector.
- ACC_CYCLES, COLS+1, cycles spent in global_state 2; the result is final in the last cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  job start pulse; sampled in IDLE only.
- skip_cfg  in  1  reuse resident weights; sampled with start.
- job_len  in  8  number of x vectors in the job; 0 is treated as 1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the job completes.
- w_valid  in  1  weight stream valid.
- w_ready  out  1  weight stream ready.
- w_data  in  DW  weight; row-major order (r0c0, r0c1, ...).
- x_valid  in  1  x-vector valid.
- x_ready  out  1  x-vector ready.
- x_data  in  COLS*DW  x vector; column c at [(c+1)*DW-1 -: DW].
- mesh_state  out  2  to mesh global_state.
- mesh_x_flat  out  COLS*DW  to mesh x_vector_flat.
- mesh_cfg_valid  out  1  to mesh cfg_valid.
- mesh_cfg_addr  out  ROW_W+COL_W  {row, col}, row in the upper bits.
- mesh_cfg_data  out  DW  to mesh cfg_data.
- mesh_result_flat  in  ROWS*2*DW  from mesh result_flat.
- res_valid  out  1  result valid.
- res_ready  in  1  result ready.
- res_data  out  ROWS*2*DW  captured result.

Behaviour:
- FSM states: IDLE, CFG, XWAIT, XLOAD, ACC, OUT.
- Reset (rst_n low at a clk edge), from any state:
  - state goes to IDLE; all counters clear; weights_loaded=0.
  - Outputs: busy=0, done=0, w_ready=0, x_ready=0, res_valid=0, mesh_state=0, mesh_cfg_valid=0, mesh_cfg_addr=0, mesh_cfg_data=0, mesh_x_flat=0, res_data=0.
- IDLE:
  - On start, latch vec_total=max(job_len,1) and clear vec_cnt.
  - Go to CFG if skip_cfg=0 or weights_loaded=0; otherwise go to XWAIT.
- CFG (mesh_state=0):
  - w_ready=1.
  - Each w_valid&&w_ready beat drives mesh_cfg_valid=1, mesh_cfg_data=w_data and mesh_cfg_addr={row_cnt,col_cnt} in the same cycle (combinational pass-through, no added latency).
  - col_cnt wraps at COLS-1 and increments row_cnt.
  - mesh_cfg_valid=0 when w_valid=0; gaps stall the sequence without advancing.
  - On the ROWS*COLS-th beat: set weights_loaded=1, clear the counters, go to XWAIT.
- XWAIT (mesh_state=0):
  - x_ready=1.
  - On x_valid: latch x_data into x_reg, go to XLOAD.
- XLOAD (mesh_state=1):
  - mesh_x_flat=x_reg for exactly XLOAD_CYCLES cycles, then go to ACC.
  - mesh_x_flat=0 in every other state.
- ACC (mesh_state=2):
  - Lasts exactly ACC_CYCLES cycles.
  - On the edge ending the last ACC cycle, res_data<=mesh_result_flat; go to OUT.
- OUT (mesh_state=0):
  - res_valid=1; res_data is held stable until res_valid&&res_ready.
  - On that handshake: vec_cnt+1. If vec_cnt+1==vec_total, pulse done and go to IDLE; else go to XWAIT.
  - res_ready low stalls indefinitely.
- Phase counter: width $clog2(max(XLOAD_CYCLES,ACC_CYCLES)+1); cleared on every phase entry.
- start outside IDLE is ignored. skip_cfg/job_len changes after the start cycle are ignored.
- A new job may start in the cycle after done.

Decomposition:
- Shared package mesh_pkg:
  - mesh state encodings MS_IDLE=2'd0, MS_XLOAD=2'd1, MS_ACC=2'd2.
  - controller FSM state typedef.
  - cfg-address packing function pack_cfg_addr(row, col).
- One sub-module, mesh_phase_cnt: a loadable down-counter with terminal-count flag, reused for the XLOAD and ACC phases.
- The FSM, cfg counters and result register stay in mesh_seq_ctrl.

Test Plan:
- Reset then start, skip_cfg=0, job_len=1, weights 1..16 streamed back-to-back:
  - mesh_cfg_addr runs 0x0..0xF with data 1..16 on consecutive cycles.
  - mesh_state=1 for 4 cycles with x_reg, then 2 for 5 cycles.
  - res_valid with the mesh result (model: row r = sum_c w[r][c]*x[c]); done pulse; busy falls.
- Weight stream with w_valid toggling 1,0,1,0 -> no addresses skipped or repeated; exactly 16 cfg_valid pulses.
- job_len=3, skip_cfg=1 after a loaded job:
  - no CFG phase; three XWAIT/XLOAD/ACC/OUT rounds.
  - done only after the 3rd result handshake.
- res_ready held low 10 cycles in OUT -> res_valid and res_data stable, mesh_state=0; proceeds on the first res_ready=1.
- rst_n low in the 2nd ACC cycle:
  - next cycle: IDLE with all outputs zero.
  - subsequent start with skip_cfg=1 still runs CFG, since weights_loaded was cleared.
- job_len=0 -> one vector processed; start asserted while busy has no effect.

Source files
------------

// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared encodings and helpers for the mesh job sequencer
package mesh_pkg;

    // Values driven onto the mesh global_state bus
    localparam logic [1:0] MS_IDLE  = 2'd0;
    localparam logic [1:0] MS_XLOAD = 2'd1;
    localparam logic [1:0] MS_ACC   = 2'd2;

    // Controller FSM state
    typedef logic [2:0] ctrl_state_t;

    localparam ctrl_state_t ST_IDLE  = 3'd0;
    localparam ctrl_state_t ST_CFG   = 3'd1;
    localparam ctrl_state_t ST_XWAIT = 3'd2;
    localparam ctrl_state_t ST_XLOAD = 3'd3;
    localparam ctrl_state_t ST_ACC   = 3'd4;
    localparam ctrl_state_t ST_OUT   = 3'd5;

    // Packs {row, col} with the row in the upper bits; caller truncates to its address width
    function automatic logic [15:0] pack_cfg_addr(input logic [7:0] row, input logic [7:0] col,
                                                  input int col_w);
        return (16'(row) << col_w) | 16'(col);
    endfunction

endpackage

// File: rtl/mesh_phase_cnt.sv
// rtl/mesh_phase_cnt.sv - loadable down-counter timing the XLOAD and ACC phases
module mesh_phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    // Load on phase entry, then count down to zero while the phase runs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A count of one marks the final cycle of the phase
    assign tc = (count == W'(1));

endmodule

// File: rtl/mesh_seq_ctrl.sv
// rtl/mesh_seq_ctrl.sv - job sequencer driving weight config, x-load and accumulate phases of the PE mesh
module mesh_seq_ctrl #(
    parameter int DW           = 8,
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int ROW_W        = 2,
    parameter int COL_W        = 2,
    parameter int XLOAD_CYCLES = ROWS,
    parameter int ACC_CYCLES   = COLS + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     skip_cfg,
    input  logic [7:0]               job_len,
    output logic                     busy,
    output logic                     done,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [DW-1:0]            w_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [COLS*DW-1:0]       x_data,
    output logic [1:0]               mesh_state,
    output logic [COLS*DW-1:0]       mesh_x_flat,
    output logic                     mesh_cfg_valid,
    output logic [ROW_W+COL_W-1:0]   mesh_cfg_addr,
    output logic [DW-1:0]            mesh_cfg_data,
    input  logic [ROWS*2*DW-1:0]     mesh_result_flat,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROWS*2*DW-1:0]     res_data
);

    import mesh_pkg::*;

    localparam int AW     = ROW_W + COL_W;
    localparam int PH_MAX = (XLOAD_CYCLES > ACC_CYCLES) ? XLOAD_CYCLES : ACC_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    ctrl_state_t          state;
    logic [7:0]           vec_total;
    logic [7:0]           vec_cnt;
    logic [ROW_W-1:0]     row_cnt;
    logic [COL_W-1:0]     col_cnt;
    logic                 weights_loaded;
    logic [COLS*DW-1:0]   x_reg;

    logic                 ph_load;
    logic [PH_W-1:0]      ph_load_val;
    logic                 ph_en;
    logic                 ph_tc;

    logic                 cfg_beat;
    logic                 last_beat;
    logic                 x_take;
    logic                 res_take;
    logic                 last_vec;

    assign cfg_beat  = (state == ST_CFG) && w_valid;
    assign last_beat = cfg_beat && (row_cnt == ROW_W'(ROWS - 1)) && (col_cnt == COL_W'(COLS - 1));
    assign x_take    = (state == ST_XWAIT) && x_valid;
    assign res_take  = (state == ST_OUT) && res_ready;
    assign last_vec  = ((vec_cnt + 8'd1) == vec_total);

    // Weight beats pass straight through to the mesh config bus in the same cycle
    assign w_ready        = (state == ST_CFG);
    assign mesh_cfg_valid = cfg_beat;
    assign mesh_cfg_data  = cfg_beat ? w_data : '0;
    assign mesh_cfg_addr  = cfg_beat ? AW'(pack_cfg_addr(8'(row_cnt), 8'(col_cnt), COL_W)) : '0;

    assign busy        = (state != ST_IDLE);
    assign x_ready     = (state == ST_XWAIT);
    assign mesh_x_flat = (state == ST_XLOAD) ? x_reg : '0;
    assign res_valid   = (state == ST_OUT);
    assign done        = res_take && last_vec;

    // Map controller state onto the mesh global_state encoding
    always_comb begin
        mesh_state = MS_IDLE;
        case (state)
            ST_XLOAD: mesh_state = MS_XLOAD;
            ST_ACC:   mesh_state = MS_ACC;
            default:  mesh_state = MS_IDLE;
        endcase
    end

    // Reload the phase counter on entry to XLOAD and on entry to ACC
    always_comb begin
        ph_load     = 1'b0;
        ph_load_val = '0;
        if (x_take) begin
            ph_load     = 1'b1;
            ph_load_val = PH_W'(XLOAD_CYCLES);
        end else if ((state == ST_XLOAD) && ph_tc) begin
            ph_load     = 1'b1;
            ph_load_val = PH_W'(ACC_CYCLES);
        end
    end

    assign ph_en = (state == ST_XLOAD) || (state == ST_ACC);

    mesh_phase_cnt #(
        .W (PH_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_load_val),
        .en       (ph_en),
        .tc       (ph_tc)
    );

    // Job sequencing FSM with cfg counters, x latch and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vec_total      <= '0;
            vec_cnt        <= '0;
            row_cnt        <= '0;
            col_cnt        <= '0;
            weights_loaded <= 1'b0;
            x_reg          <= '0;
            res_data       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec_total <= (job_len == 8'd0) ? 8'd1 : job_len;
                        vec_cnt   <= '0;
                        state     <= (!skip_cfg || !weights_loaded) ? ST_CFG : ST_XWAIT;
                    end
                end
                ST_CFG: begin
                    if (last_beat) begin
                        weights_loaded <= 1'b1;
                        row_cnt        <= '0;
                        col_cnt        <= '0;
                        state          <= ST_XWAIT;
                    end else if (cfg_beat) begin
                        if (col_cnt == COL_W'(COLS - 1)) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 1'b1;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                ST_XWAIT: begin
                    if (x_valid) begin
                        x_reg <= x_data;
                        state <= ST_XLOAD;
                    end
                end
                ST_XLOAD: begin
                    if (ph_tc) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (ph_tc) begin
                        res_data <= mesh_result_flat;
                        state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        vec_cnt <= vec_cnt + 8'd1;
                        state   <= last_vec ? ST_IDLE : ST_XWAIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesh_seq_ctrl.sv
// tb/tb_mesh_seq_ctrl.sv - self-checking bench for mesh_seq_ctrl with a behavioural mesh model
module tb_mesh_seq_ctrl;

    localparam int XL  = 4;
    localparam int ACC = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        skip_cfg;
    logic [7:0]  job_len;
    logic        busy;
    logic        done;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  w_data;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_data;
    logic [1:0]  mesh_state;
    logic [31:0] mesh_x_flat;
    logic        mesh_cfg_valid;
    logic [3:0]  mesh_cfg_addr;
    logic [7:0]  mesh_cfg_data;
    logic [63:0] mesh_result_flat;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0]  w_tb   [16];
    logic [7:0]  mesh_w [16];
    logic [31:0] x_mesh;
    int          acc_seen = 0;

    logic [63:0] res_q [$];
    logic [11:0] cfg_q [$];

    always #5 clk = ~clk;

    mesh_seq_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .skip_cfg         (skip_cfg),
        .job_len          (job_len),
        .busy             (busy),
        .done             (done),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .w_data           (w_data),
        .x_valid          (x_valid),
        .x_ready          (x_ready),
        .x_data           (x_data),
        .mesh_state       (mesh_state),
        .mesh_x_flat      (mesh_x_flat),
        .mesh_cfg_valid   (mesh_cfg_valid),
        .mesh_cfg_addr    (mesh_cfg_addr),
        .mesh_cfg_data    (mesh_cfg_data),
        .mesh_result_flat (mesh_result_flat),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data)
    );

    // row r = sum_c w[r][c] * x[c], row r at bits [r*16 +: 16]
    function automatic logic [63:0] mesh_calc(input logic [7:0] w [16], input logic [31:0] x);
        logic [63:0] r = '0;
        logic [15:0] s;
        for (int i = 0; i < 4; i++) begin
            s = '0;
            for (int c = 0; c < 4; c++) begin
                s = s + 16'(w[i*4+c]) * 16'(x[c*8 +: 8]);
            end
            r[i*16 +: 16] = s;
        end
        return r;
    endfunction

    // Mesh model: stores cfg writes, latches x during XLOAD, counts ACC cycles
    always @(posedge clk) begin
        if (mesh_cfg_valid) mesh_w[mesh_cfg_addr] <= mesh_cfg_data;
        if (mesh_state == 2'd1) x_mesh <= mesh_x_flat;
        acc_seen <= (mesh_state == 2'd2) ? acc_seen + 1 : 0;
    end

    // Result is only correct in the final ACC cycle; junk otherwise
    assign mesh_result_flat = ((mesh_state == 2'd2) && (acc_seen == ACC - 1))
                              ? mesh_calc(mesh_w, x_mesh) : {4{16'hBAD0}};

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; skip_cfg = 1'b0; job_len = 8'd0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic skip, input logic [7:0] len, input logic exp_cfg);
        @(negedge clk);
        start = 1'b1; skip_cfg = skip; job_len = len;
        @(negedge clk);
        start = 1'b0; skip_cfg = ~skip; job_len = 8'hAA;
        #1;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy);
        else pass_cnt++;
        chk_cnt++;
        if (w_ready !== exp_cfg) $display("FAIL start_cfg_path: w_ready got %b want %b", w_ready, exp_cfg);
        else pass_cnt++;
    endtask

    task automatic load_weights(input bit gap);
        int i = 0;
        int t = 0;
        int pulses = 0;
        logic [11:0] e;
        while (i < 16 && t < 200) begin
            @(negedge clk);
            if (gap && t[0]) begin
                w_valid = 1'b0;
            end else begin
                w_valid = 1'b1;
                w_data  = w_tb[i];
            end
            #1;
            if (w_valid && w_ready) begin
                cfg_q.push_back({i[3:0], w_tb[i]});
                i++;
            end
            if (mesh_cfg_valid) begin
                pulses++;
                e = (cfg_q.size() > 0) ? cfg_q.pop_front() : 12'hFFF;
                chk_cnt++;
                if ({mesh_cfg_addr, mesh_cfg_data} !== e)
                    $display("FAIL cfg_beat: got addr %h data %h want addr %h data %h",
                             mesh_cfg_addr, mesh_cfg_data, e[11:8], e[7:0]);
                else pass_cnt++;
            end
            t++;
        end
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = 8'h5A;
        #1;
        chk_cnt++;
        if (mesh_cfg_valid !== 1'b0 || x_ready !== 1'b1)
            $display("FAIL cfg_end: cfg_valid got %b want 0, x_ready got %b want 1", mesh_cfg_valid, x_ready);
        else pass_cnt++;
        w_valid = 1'b0;
        chk_cnt++;
        if (pulses !== 16 || cfg_q.size() !== 0)
            $display("FAIL cfg_pulses: got %0d pulses (%0d pending) want 16 (0)", pulses, cfg_q.size());
        else pass_cnt++;
        chk_cnt++;
        if (t !== (gap ? 31 : 16)) $display("FAIL cfg_cycles: got %0d want %0d", t, gap ? 31 : 16);
        else pass_cnt++;
    endtask

    task automatic run_vector(input logic [31:0] x, input int stall, input bit last);
        int t = 0;
        int n1 = 0;
        int n2 = 0;
        bit xok = 1'b1;
        bit sok = 1'b1;
        logic [63:0] held;
        logic [63:0] exp;
        @(negedge clk);
        #1;
        while (!x_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk_cnt++;
        if (x_ready !== 1'b1) $display("FAIL xwait: x_ready got %b want 1 (timeout)", x_ready);
        else pass_cnt++;
        x_valid = 1'b1;
        x_data  = x;
        res_q.push_back(mesh_calc(w_tb, x));
        @(negedge clk);
        x_valid = 1'b0;
        x_data  = $urandom;
        #1;
        while (mesh_state == 2'd1 && n1 < 20) begin
            if (mesh_x_flat !== x) xok = 1'b0;
            n1++;
            @(negedge clk);
            #1;
        end
        chk_cnt++;
        if (n1 !== XL) $display("FAIL xload_len: got %0d cycles want %0d", n1, XL);
        else pass_cnt++;
        chk_cnt++;
        if (!xok) $display("FAIL xload_data: mesh_x_flat got %h want %h", mesh_x_flat, x);
        else pass_cnt++;
        while (mesh_state == 2'd2 && n2 < 20) begin
            n2++;
            @(negedge clk);
            #1;
        end
        chk_cnt++;
        if (n2 !== ACC) $display("FAIL acc_len: got %0d cycles want %0d", n2, ACC);
        else pass_cnt++;
        chk_cnt++;
        if (res_valid !== 1'b1) $display("FAIL res_valid: got %b want 1", res_valid);
        else pass_cnt++;
        held = res_data;
        for (int k = 0; k < stall; k++) begin
            if (res_valid !== 1'b1 || res_data !== held || mesh_state !== 2'd0 || done !== 1'b0) sok = 1'b0;
            @(negedge clk);
            #1;
        end
        if (stall > 0) begin
            chk_cnt++;
            if (!sok || res_data !== held)
                $display("FAIL res_stall: res_data got %h want %h held", res_data, held);
            else pass_cnt++;
        end
        start     = 1'b0;
        res_ready = 1'b1;
        #1;
        chk_cnt++;
        if (done !== last) $display("FAIL done_pulse: got %b want %b", done, last);
        else pass_cnt++;
        exp = res_q.pop_front();
        chk_cnt++;
        if (res_data !== exp) $display("FAIL res_data: got %h want %h", res_data, exp);
        else pass_cnt++;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk_cnt++;
        if (busy !== !last || done !== 1'b0)
            $display("FAIL post_handshake: busy got %b want %b, done got %b want 0", busy, !last, done);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        chk_cnt++;
        if ({busy, done, w_ready, x_ready, res_valid, mesh_state, mesh_cfg_valid,
             mesh_cfg_addr, mesh_cfg_data, mesh_x_flat, res_data} !== '0)
            $display("FAIL reset_outputs: busy %b done %b w_ready %b x_ready %b res_valid %b mesh_state %h cfg %b/%h/%h x %h res %h want all 0",
                     busy, done, w_ready, x_ready, res_valid, mesh_state, mesh_cfg_valid,
                     mesh_cfg_addr, mesh_cfg_data, mesh_x_flat, res_data);
        else pass_cnt++;
    endtask

    task automatic test_single_job;
        for (int i = 0; i < 16; i++) w_tb[i] = 8'(i + 1);
        do_start(1'b0, 8'd1, 1'b1);
        load_weights(1'b0);
        run_vector(32'h04030201, 0, 1'b1);
    endtask

    task automatic test_cfg_gaps;
        for (int i = 0; i < 16; i++) w_tb[i] = 8'(i * 7 + 3);
        do_start(1'b0, 8'd1, 1'b1);
        load_weights(1'b1);
        run_vector(32'h0A09FF02, 0, 1'b1);
    endtask

    task automatic test_back_to_back;
        do_start(1'b1, 8'd3, 1'b0);
        for (int v = 0; v < 3; v++) run_vector($urandom, 0, v == 2);
    endtask

    task automatic test_res_stall;
        do_start(1'b1, 8'd1, 1'b0);
        run_vector(32'h11223344, 10, 1'b1);
    endtask

    task automatic test_reset_in_acc;
        int t = 0;
        do_start(1'b1, 8'd1, 1'b0);
        x_valid = 1'b1;
        x_data  = 32'h01010101;
        @(negedge clk);
        x_valid = 1'b0;
        #1;
        while (mesh_state !== 2'd2 && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk_cnt++;
        if (mesh_state !== 2'd2) $display("FAIL acc_reach: mesh_state got %h want 2", mesh_state);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk_cnt++;
        if ({busy, done, w_ready, x_ready, res_valid, mesh_state, mesh_cfg_valid,
             mesh_cfg_addr, mesh_cfg_data, mesh_x_flat, res_data} !== '0)
            $display("FAIL acc_reset_outputs: busy %b mesh_state %h res_valid %b x %h res %h want all 0",
                     busy, mesh_state, res_valid, mesh_x_flat, res_data);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) w_tb[i] = 8'(255 - i * 5);
        do_start(1'b1, 8'd1, 1'b1);
        load_weights(1'b0);
        run_vector(32'h05060708, 0, 1'b1);
    endtask

    task automatic test_len_zero;
        do_start(1'b1, 8'd0, 1'b0);
        start    = 1'b1;
        skip_cfg = 1'b0;
        job_len  = 8'd5;
        run_vector(32'h80402010, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_cfg_gaps();
        test_back_to_back();
        test_res_stall();
        test_reset_in_acc();
        test_len_zero();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
